// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the data-port arbiter: FSM states, read-return owner codes, bus widths.
// No logic; imported by the arbiter, its interface and the bench.
// Owner codes tag which master a registered read belongs to.
package mem_port_arbiter_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;

  localparam int STARVE_LIMIT_DEF = 4;
  localparam int MAX_BURST_DEF    = 8;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] data_t;

  typedef enum logic {
    ARB       = 1'b0,
    EXT_BURST = 1'b1
  } arb_state_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_EXT  = 2'd2
  } owner_e;

  // Counter width able to hold 0..limit, never narrower than one bit.
  function automatic int cnt_width(input int limit);
    return (limit < 1) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of CPU-side, external-master-side and memory-side signals of the shared data port.
// Pure wiring, no latency.
// slave = the arbiter; master = the environment (CPU, external master and memory together).
interface mem_port_arbiter_if;
  import mem_port_arbiter_pkg::*;

  logic  cpu_req;
  logic  cpu_we;
  addr_t cpu_addr;
  data_t cpu_wdata;
  logic  cpu_gnt;
  logic  cpu_rvalid;

  logic  ext_req;
  logic  ext_we;
  logic  ext_lock;
  addr_t ext_addr;
  data_t ext_wdata;
  logic  ext_gnt;
  logic  ext_rvalid;

  logic  mem_ren;
  logic  mem_we;
  addr_t mem_addr;
  data_t mem_wdata;
  data_t mem_rdata;

  // mem_rdata goes straight from the memory to both masters; the arbiter only flags ownership.
  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  ext_req, ext_we, ext_lock, ext_addr, ext_wdata,
    output cpu_gnt, cpu_rvalid, ext_gnt, ext_rvalid,
    output mem_ren, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output ext_req, ext_we, ext_lock, ext_addr, ext_wdata,
    output mem_rdata,
    input  cpu_gnt, cpu_rvalid, ext_gnt, ext_rvalid,
    input  mem_ren, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/mem_port_arbiter_sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
// Count visible the cycle after inc/clr; at_limit is a decode of the current count.
// No handshake; holds at LIMIT instead of wrapping.
module mem_port_arbiter_sat_counter #(
  parameter int WIDTH = 3,
  parameter int LIMIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] cnt,
  output logic             at_limit
);

  localparam logic [WIDTH-1:0] LIM = WIDTH'(LIMIT);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  assign at_limit = (cnt_q == LIM);
  assign cnt      = cnt_q;

  // Next count: clear first, otherwise increment until the limit is reached.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && !at_limit) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the CPU data port and an external master onto one 1-cycle-latency memory port.
// Grants are combinational in the request cycle; read data returns with rvalid one cycle later.
// Loser stalls (req & ~gnt); CPU wins by default, starvation counter and locked bursts favour ext.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF,
  parameter int MAX_BURST    = MAX_BURST_DEF
) (
  input logic               clk,
  input logic               rst,
  mem_port_arbiter_if.slave bus
);

  localparam int SW = cnt_width(STARVE_LIMIT);
  localparam int BW = cnt_width(MAX_BURST);
  // burst_cnt value on the beat that completes a full burst
  localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);

  arb_state_e state_q, state_d;
  logic       cpu_first_q, cpu_first_d;
  owner_e     rd_owner_q, rd_owner_d;

  logic          cpu_gnt, ext_gnt;
  logic          starve_inc, starve_clr, starve_at_limit;
  logic          burst_inc, burst_clr, burst_at_limit;
  logic [SW-1:0] starve_cnt;
  logic [BW-1:0] burst_cnt;
  logic          unused_cnt;

  mem_port_arbiter_sat_counter #(.WIDTH(SW), .LIMIT(STARVE_LIMIT)) u_starve (
    .clk(clk), .rst(rst), .inc(starve_inc), .clr(starve_clr),
    .cnt(starve_cnt), .at_limit(starve_at_limit)
  );

  mem_port_arbiter_sat_counter #(.WIDTH(BW), .LIMIT(MAX_BURST)) u_burst (
    .clk(clk), .rst(rst), .inc(burst_inc), .clr(burst_clr),
    .cnt(burst_cnt), .at_limit(burst_at_limit)
  );

  // The starvation count is only consumed via at_limit; burst end is detected one beat early.
  assign unused_cnt = ^{starve_cnt, burst_at_limit};

  // FSM next state, grants and counter controls. Grants are forced low while in reset.
  always_comb begin
    state_d     = state_q;
    cpu_first_d = cpu_first_q;
    cpu_gnt     = 1'b0;
    ext_gnt     = 1'b0;
    starve_inc  = 1'b0;
    starve_clr  = 1'b0;
    burst_inc   = 1'b0;
    burst_clr   = 1'b0;
    if (!rst) begin
      case (state_q)
        ARB: begin
          cpu_first_d = 1'b0;
          if (bus.cpu_req && bus.ext_req) begin
            if (starve_at_limit && !cpu_first_q) begin
              ext_gnt = 1'b1;
            end else begin
              cpu_gnt    = 1'b1;
              starve_inc = 1'b1;
            end
          end else if (bus.cpu_req) begin
            cpu_gnt = 1'b1;
          end else if (bus.ext_req) begin
            ext_gnt = 1'b1;
          end
          if (ext_gnt || !bus.ext_req) begin
            starve_clr = 1'b1;
          end
          // A locked grant in ARB is beat 1 of the burst.
          if (ext_gnt && bus.ext_lock) begin
            if (MAX_BURST == 1) begin
              cpu_first_d = 1'b1;
            end else begin
              state_d   = EXT_BURST;
              burst_inc = 1'b1;
            end
          end
        end
        EXT_BURST: begin
          if (bus.ext_req && bus.ext_lock) begin
            ext_gnt = 1'b1;
            if (burst_cnt == BURST_LAST) begin
              state_d     = ARB;
              cpu_first_d = 1'b1;
              burst_clr   = 1'b1;
            end else begin
              burst_inc = 1'b1;
            end
          end else begin
            // Master released the lock: idle this cycle, normal arbitration next cycle.
            state_d   = ARB;
            burst_clr = 1'b1;
          end
        end
        default: begin
          state_d = ARB;
        end
      endcase
    end
  end

  // Memory drive from the winner and read-owner tag for the return cycle.
  always_comb begin
    bus.mem_ren   = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    rd_owner_d    = OWN_NONE;
    if (cpu_gnt) begin
      bus.mem_ren   = !bus.cpu_we;
      bus.mem_we    = bus.cpu_we;
      bus.mem_addr  = bus.cpu_addr;
      bus.mem_wdata = bus.cpu_wdata;
      rd_owner_d    = bus.cpu_we ? OWN_NONE : OWN_CPU;
    end else if (ext_gnt) begin
      bus.mem_ren   = !bus.ext_we;
      bus.mem_we    = bus.ext_we;
      bus.mem_addr  = bus.ext_addr;
      bus.mem_wdata = bus.ext_wdata;
      rd_owner_d    = bus.ext_we ? OWN_NONE : OWN_EXT;
    end
  end

  // State registers; reset drops any burst and any read in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ARB;
      cpu_first_q <= 1'b0;
      rd_owner_q  <= OWN_NONE;
    end else begin
      state_q     <= state_d;
      cpu_first_q <= cpu_first_d;
      rd_owner_q  <= rd_owner_d;
    end
  end

  assign bus.cpu_gnt    = cpu_gnt;
  assign bus.ext_gnt    = ext_gnt;
  assign bus.cpu_rvalid = (rd_owner_q == OWN_CPU);
  assign bus.ext_rvalid = (rd_owner_q == OWN_EXT);

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  logic clk;
  logic rst;

  mem_port_arbiter_if bus();

  mem_port_arbiter #(.STARVE_LIMIT(4), .MAX_BURST(8)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous memory, 1-cycle read latency. Unwritten words read as addr ^ 0xA5A5.
  logic [15:0] mem_arr [0:65535];
  bit          mem_written [0:65535];
  always @(posedge clk) begin
    if (bus.mem_we === 1'b1) begin
      mem_arr[bus.mem_addr]     <= bus.mem_wdata;
      mem_written[bus.mem_addr] <= 1'b1;
    end
    if (bus.mem_ren === 1'b1) begin
      bus.mem_rdata <= mem_written[bus.mem_addr] ? mem_arr[bus.mem_addr]
                                                 : (bus.mem_addr ^ 16'hA5A5);
    end
  end

  // Reference memory contents, updated when the bench expects a write to be granted.
  logic [15:0] wr_model [int];

  function automatic logic [15:0] model_rd(input logic [15:0] a);
    if (wr_model.exists(int'(a))) return wr_model[int'(a)];
    return a ^ 16'hA5A5;
  endfunction

  typedef struct {
    int          due;
    logic        is_cpu;
    logic [15:0] data;
  } rd_exp_t;

  rd_exp_t sbq[$];
  int      cyc;
  int      tests_run;
  int      tests_failed;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drv_cpu(input logic req, input logic we, input logic [15:0] addr,
                         input logic [15:0] wd);
    bus.cpu_req   = req;
    bus.cpu_we    = we;
    bus.cpu_addr  = addr;
    bus.cpu_wdata = wd;
  endtask

  task automatic drv_ext(input logic req, input logic we, input logic lock,
                         input logic [15:0] addr, input logic [15:0] wd);
    bus.ext_req   = req;
    bus.ext_we    = we;
    bus.ext_lock  = lock;
    bus.ext_addr  = addr;
    bus.ext_wdata = wd;
  endtask

  // Entered just after a posedge with inputs already driven; checks this cycle, then advances.
  task automatic step(input logic ecg, input logic eeg, input string tag);
    logic        e_ren, e_we, e_crv, e_erv, have;
    logic [15:0] e_addr, e_wd, e_rd;
    rd_exp_t     e;
    #3;
    e_ren  = (ecg & ~bus.cpu_we) | (eeg & ~bus.ext_we);
    e_we   = (ecg & bus.cpu_we) | (eeg & bus.ext_we);
    e_addr = ecg ? bus.cpu_addr : (eeg ? bus.ext_addr : 16'h0);
    e_wd   = ecg ? bus.cpu_wdata : (eeg ? bus.ext_wdata : 16'h0);
    e_crv  = 1'b0;
    e_erv  = 1'b0;
    e_rd   = 16'h0;
    have   = 1'b0;
    if (sbq.size() != 0 && sbq[0].due == cyc) begin
      e     = sbq.pop_front();
      have  = 1'b1;
      e_crv = e.is_cpu;
      e_erv = !e.is_cpu;
      e_rd  = e.data;
    end
    chk({tag, ".cpu_gnt"},    bus.cpu_gnt,    ecg);
    chk({tag, ".ext_gnt"},    bus.ext_gnt,    eeg);
    chk({tag, ".mem_ren"},    bus.mem_ren,    e_ren);
    chk({tag, ".mem_we"},     bus.mem_we,     e_we);
    chk({tag, ".mem_addr"},   bus.mem_addr,   e_addr);
    chk({tag, ".mem_wdata"},  bus.mem_wdata,  e_wd);
    chk({tag, ".cpu_rvalid"}, bus.cpu_rvalid, e_crv);
    chk({tag, ".ext_rvalid"}, bus.ext_rvalid, e_erv);
    if (have) chk({tag, ".mem_rdata"}, bus.mem_rdata, e_rd);
    if (ecg) begin
      if (bus.cpu_we) wr_model[int'(bus.cpu_addr)] = bus.cpu_wdata;
      else sbq.push_back('{due: cyc + 1, is_cpu: 1'b1, data: model_rd(bus.cpu_addr)});
    end
    if (eeg) begin
      if (bus.ext_we) wr_model[int'(bus.ext_addr)] = bus.ext_wdata;
      else sbq.push_back('{due: cyc + 1, is_cpu: 1'b0, data: model_rd(bus.ext_addr)});
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".cpu_gnt"},    bus.cpu_gnt,    16'h0);
    chk({tag, ".ext_gnt"},    bus.ext_gnt,    16'h0);
    chk({tag, ".cpu_rvalid"}, bus.cpu_rvalid, 16'h0);
    chk({tag, ".ext_rvalid"}, bus.ext_rvalid, 16'h0);
    chk({tag, ".mem_ren"},    bus.mem_ren,    16'h0);
    chk({tag, ".mem_we"},     bus.mem_we,     16'h0);
    chk({tag, ".mem_addr"},   bus.mem_addr,   16'h0);
    chk({tag, ".mem_wdata"},  bus.mem_wdata,  16'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach the summary in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int beats;
    tests_run    = 0;
    tests_failed = 0;
    cyc          = 0;

    // Reset with requests pending: everything must stay low.
    rst = 1'b1;
    drv_cpu(1'b1, 1'b0, 16'h0010, 16'h0);
    drv_ext(1'b1, 1'b0, 1'b1, 16'h0011, 16'h0);
    #2;
    chk_all_zero("reset");
    @(posedge clk);
    #1;
    drv_cpu(1'b0, 1'b0, 16'h0, 16'h0);
    drv_ext(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    rst = 1'b0;

    // 1: solo CPU read, rvalid exactly one cycle later.
    step(1'b0, 1'b0, "t1.idle0");
    step(1'b0, 1'b0, "t1.idle1");
    drv_cpu(1'b1, 1'b0, 16'h0010, 16'h0);
    step(1'b1, 1'b0, "t1.read");
    drv_cpu(1'b0, 1'b0, 16'h0, 16'h0);
    step(1'b0, 1'b0, "t1.ret");
    step(1'b0, 1'b0, "t1.after");

    // 2: contention without lock, ext forced through every fifth cycle.
    for (int i = 0; i < 10; i++) begin
      drv_cpu(1'b1, 1'b0, 16'h0200 + 16'(i), 16'h0);
      drv_ext(1'b1, 1'b0, 1'b0, 16'h0300 + 16'(i), 16'h0);
      step((i != 4 && i != 9), (i == 4 || i == 9), $sformatf("t2.c%0d", i));
    end
    drv_cpu(1'b0, 1'b0, 16'h0, 16'h0);
    drv_ext(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    step(1'b0, 1'b0, "t2.drain");

    // 3: locked 8-beat ext burst entered through starvation; CPU gets the next cycle.
    beats = 0;
    for (int i = 0; i < 13; i++) begin
      logic eg;
      eg = (i >= 4 && i <= 11);
      drv_cpu(1'b1, 1'b0, 16'h0400 + 16'(i), 16'h0);
      drv_ext(1'b1, 1'b0, 1'b1, 16'h0100 + 16'(beats), 16'h0);
      step(!eg, eg, $sformatf("t3.c%0d", i));
      if (eg) beats++;
    end
    drv_ext(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    step(1'b1, 1'b0, "t3.cpu_solo");
    drv_cpu(1'b0, 1'b0, 16'h0, 16'h0);
    step(1'b0, 1'b0, "t3.drain");

    // 4: lock dropped after 3 beats -> dead cycle, then CPU.
    drv_ext(1'b1, 1'b0, 1'b1, 16'h0500, 16'h0);
    step(1'b0, 1'b1, "t4.b1");
    drv_cpu(1'b1, 1'b0, 16'h0600, 16'h0);
    drv_ext(1'b1, 1'b0, 1'b1, 16'h0501, 16'h0);
    step(1'b0, 1'b1, "t4.b2");
    drv_ext(1'b1, 1'b0, 1'b1, 16'h0502, 16'h0);
    step(1'b0, 1'b1, "t4.b3");
    drv_ext(1'b1, 1'b0, 1'b0, 16'h0503, 16'h0);
    step(1'b0, 1'b0, "t4.unlock");
    step(1'b1, 1'b0, "t4.cpu");
    drv_cpu(1'b0, 1'b0, 16'h0, 16'h0);
    drv_ext(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    step(1'b0, 1'b0, "t4.drain");

    // 5: write-then-read ordering across owners, alternating read returns.
    drv_ext(1'b1, 1'b1, 1'b0, 16'h0020, 16'hBEEF);
    step(1'b0, 1'b1, "t5.ext_wr");
    drv_ext(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    drv_cpu(1'b1, 1'b0, 16'h0020, 16'h0);
    step(1'b1, 1'b0, "t5.cpu_rd");
    drv_cpu(1'b1, 1'b1, 16'h0030, 16'h1234);
    step(1'b1, 1'b0, "t5.cpu_wr");
    drv_cpu(1'b0, 1'b0, 16'h0, 16'h0);
    drv_ext(1'b1, 1'b0, 1'b0, 16'h0030, 16'h0);
    step(1'b0, 1'b1, "t5.ext_rd");
    drv_ext(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    drv_cpu(1'b1, 1'b0, 16'h0031, 16'h0);
    step(1'b1, 1'b0, "t5.cpu_rd2");
    drv_cpu(1'b0, 1'b0, 16'h0, 16'h0);
    drv_ext(1'b1, 1'b0, 1'b0, 16'h0032, 16'h0);
    step(1'b0, 1'b1, "t5.ext_rd2");
    drv_ext(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    step(1'b0, 1'b0, "t5.drain");

    // 6: reset mid-burst with an ext read in flight.
    drv_ext(1'b1, 1'b0, 1'b1, 16'h0700, 16'h0);
    step(1'b0, 1'b1, "t6.b1");
    drv_cpu(1'b1, 1'b0, 16'h0800, 16'h0);
    drv_ext(1'b1, 1'b0, 1'b1, 16'h0701, 16'h0);
    step(1'b0, 1'b1, "t6.b2");
    rst = 1'b1;
    #1;
    chk_all_zero("t6.in_reset");
    @(posedge clk);
    @(posedge clk);
    #1;
    chk_all_zero("t6.held");
    rst = 1'b0;
    sbq.delete();
    step(1'b1, 1'b0, "t6.post_contest");
    drv_cpu(1'b0, 1'b0, 16'h0, 16'h0);
    drv_ext(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    step(1'b0, 1'b0, "t6.ret");
    step(1'b0, 1'b0, "t6.drain");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
